// File: rtl/axi_pkg.sv
// Shared types for the AXI memory slave: burst/response encodings and FSM states.
package axi_pkg;

  localparam int AxiIdWidth = 4;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

  // Burst-level response decided at the address handshake.
  // Out-of-range wins over an unsupported burst type.
  function automatic resp_t decode_resp(input logic in_range, input logic [1:0] burst);
    if (!in_range) return DECERR;
    if (burst == FIXED || burst == INCR) return OKAY;
    return SLVERR;
  endfunction

endpackage

// File: rtl/axi_if.sv
// Per-channel AXI interfaces; the memory slave uses the slave modports.
interface axi_aw_if #(
  parameter int AddrWidth = 32,
  parameter int IdWidth   = axi_pkg::AxiIdWidth
);
  logic [IdWidth-1:0]   awid;
  logic [AddrWidth-1:0] awaddr;
  logic [7:0]           awlen;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready;
  modport master (output awid, awaddr, awlen, awburst, awvalid, input awready);
  modport slave  (input awid, awaddr, awlen, awburst, awvalid, output awready);
endinterface

interface axi_w_if #(
  parameter int DataWidth = 128
);
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  modport master (output wdata, wstrb, wlast, wvalid, input wready);
  modport slave  (input wdata, wstrb, wlast, wvalid, output wready);
endinterface

interface axi_b_if #(
  parameter int IdWidth = axi_pkg::AxiIdWidth
);
  logic [IdWidth-1:0] bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  modport master (input bid, bresp, bvalid, output bready);
  modport slave  (output bid, bresp, bvalid, input bready);
endinterface

interface axi_ar_if #(
  parameter int AddrWidth = 32,
  parameter int IdWidth   = axi_pkg::AxiIdWidth
);
  logic [IdWidth-1:0]   arid;
  logic [AddrWidth-1:0] araddr;
  logic [7:0]           arlen;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;
  modport master (output arid, araddr, arlen, arburst, arvalid, input arready);
  modport slave  (input arid, araddr, arlen, arburst, arvalid, output arready);
endinterface

interface axi_r_if #(
  parameter int DataWidth = 128,
  parameter int IdWidth   = axi_pkg::AxiIdWidth
);
  logic [IdWidth-1:0]   rid;
  logic [DataWidth-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;
  modport master (input rid, rdata, rresp, rlast, rvalid, output rready);
  modport slave  (output rid, rdata, rresp, rlast, rvalid, input rready);
endinterface

// File: rtl/axi_mem_slave_ram.sv
// One-write/one-read synchronous RAM with byte enables; reads return pre-write data.
module axi_mem_slave_ram #(
  parameter int DataWidth = 128,
  parameter int Depth     = 1024,
  parameter int AddrBits  = $clog2(Depth)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AddrBits-1:0]    waddr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  input  logic                   re_i,
  input  logic [AddrBits-1:0]    raddr_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Read and byte-masked write share one edge so a colliding read sees old data.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int b = 0; b < DataWidth/8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI memory slave: independent write and read FSMs over a dual-port RAM.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int                   AxiBusWidth = 128,
  parameter int                   AddrWidth   = 32,
  parameter int                   MemDepth    = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr    = 'h0002_0000
) (
  input logic     aclk,
  input logic     rst,
  axi_aw_if.slave axi_s_aw,
  axi_w_if.slave  axi_s_w,
  axi_b_if.slave  axi_s_b,
  axi_ar_if.slave axi_s_ar,
  axi_r_if.slave  axi_s_r
);

  localparam int ByteShift = $clog2(AxiBusWidth/8);
  localparam int IdxWidth  = $clog2(MemDepth);
  typedef logic [IdxWidth-1:0] idx_t;

  // ---------------- write path ----------------
  w_state_t              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [AxiIdWidth-1:0] bid_q;
  resp_t                 bresp_q, w_err_q;
  logic [7:0]            w_len_q;
  logic                  w_incr_q, w_mis_q;
  logic [8:0]            w_cnt_q;
  idx_t                  w_idx_q;
  logic [AddrWidth-1:0]  aw_word;
  logic                  aw_hs, w_hs, b_hs, w_in_burst, w_mis_now, ram_we;

  assign aw_word    = (axi_s_aw.awaddr - BaseAddr) >> ByteShift;
  assign aw_hs      = axi_s_aw.awvalid && awready_q;
  assign w_hs       = axi_s_w.wvalid && wready_q;
  assign b_hs       = bvalid_q && axi_s_b.bready;
  assign w_in_burst = w_cnt_q <= {1'b0, w_len_q};
  assign w_mis_now  = !w_in_burst || (axi_s_w.wlast && w_cnt_q != {1'b0, w_len_q});
  assign ram_we     = w_hs && w_in_burst && (w_err_q == OKAY);

  // Write FSM state and registered handshake outputs.
  always_ff @(posedge aclk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Write FSM next state.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && axi_s_w.wlast) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs, decoded from the next state so they are registered.
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write burst bookkeeping: latch AW, count beats, accumulate response.
  always_ff @(posedge aclk) begin
    if (rst) begin
      bid_q    <= '0;
      bresp_q  <= OKAY;
      w_err_q  <= OKAY;
      w_len_q  <= '0;
      w_incr_q <= 1'b0;
      w_mis_q  <= 1'b0;
      w_cnt_q  <= '0;
      w_idx_q  <= '0;
    end else begin
      if (aw_hs) begin
        bid_q    <= axi_s_aw.awid;
        w_len_q  <= axi_s_aw.awlen;
        w_incr_q <= (axi_s_aw.awburst == INCR);
        w_err_q  <= decode_resp((axi_s_aw.awaddr >= BaseAddr) && (aw_word < AddrWidth'(MemDepth)),
                                axi_s_aw.awburst);
        w_idx_q  <= aw_word[IdxWidth-1:0];
        w_cnt_q  <= '0;
        w_mis_q  <= 1'b0;
      end
      if (w_hs) begin
        if (w_in_burst) begin
          w_cnt_q <= w_cnt_q + 9'd1;
          if (w_incr_q) w_idx_q <= w_idx_q + IdxWidth'(1);
        end
        if (w_mis_now) w_mis_q <= 1'b1;
        if (axi_s_w.wlast) begin
          if (w_err_q != OKAY)          bresp_q <= w_err_q;
          else if (w_mis_q || w_mis_now) bresp_q <= SLVERR;
          else                           bresp_q <= OKAY;
        end
      end
    end
  end

  assign axi_s_aw.awready = awready_q;
  assign axi_s_w.wready   = wready_q;
  assign axi_s_b.bvalid   = bvalid_q;
  assign axi_s_b.bid      = bid_q;
  assign axi_s_b.bresp    = bresp_q;

  // ---------------- read path ----------------
  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  resp_t                 rresp_q, rresp_d, r_err_q;
  logic [AxiIdWidth-1:0] rid_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic                  r_incr_q;
  idx_t                  r_idx_q;
  logic [AddrWidth-1:0]  ar_word;
  logic                  ar_hs, r_hs;
  logic [AxiBusWidth-1:0] ram_rdata;

  assign ar_word = (axi_s_ar.araddr - BaseAddr) >> ByteShift;
  assign ar_hs   = axi_s_ar.arvalid && arready_q;
  assign r_hs    = rvalid_q && axi_s_r.rready;

  // Read FSM state and registered R-channel outputs.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read FSM next state; each beat costs one fetch cycle plus one data cycle.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (r_hs) r_state_d = rlast_q ? R_IDLE : R_FETCH;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; beat attributes load on fetch and hold through stalls.
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    if (r_state_q == R_FETCH) begin
      rlast_d = (r_cnt_q == r_len_q);
      rresp_d = r_err_q;
    end else if (r_hs) begin
      rlast_d = 1'b0;
    end
  end

  // Read burst bookkeeping: latch AR and advance per accepted beat.
  always_ff @(posedge aclk) begin
    if (rst) begin
      rid_q    <= '0;
      r_err_q  <= OKAY;
      r_len_q  <= '0;
      r_incr_q <= 1'b0;
      r_cnt_q  <= '0;
      r_idx_q  <= '0;
    end else begin
      if (ar_hs) begin
        rid_q    <= axi_s_ar.arid;
        r_len_q  <= axi_s_ar.arlen;
        r_incr_q <= (axi_s_ar.arburst == INCR);
        r_err_q  <= decode_resp((axi_s_ar.araddr >= BaseAddr) && (ar_word < AddrWidth'(MemDepth)),
                                axi_s_ar.arburst);
        r_idx_q  <= ar_word[IdxWidth-1:0];
        r_cnt_q  <= '0;
      end
      if (r_hs) begin
        r_cnt_q <= r_cnt_q + 8'd1;
        if (r_incr_q) r_idx_q <= r_idx_q + IdxWidth'(1);
      end
    end
  end

  assign axi_s_ar.arready = arready_q;
  assign axi_s_r.rvalid   = rvalid_q;
  assign axi_s_r.rlast    = rlast_q;
  assign axi_s_r.rresp    = rresp_q;
  assign axi_s_r.rid      = rid_q;
  assign axi_s_r.rdata    = (rvalid_q && rresp_q == OKAY) ? ram_rdata : '0;

  axi_mem_slave_ram #(
    .DataWidth (AxiBusWidth),
    .Depth     (MemDepth),
    .AddrBits  (IdxWidth)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (w_idx_q),
    .wdata_i (axi_s_w.wdata),
    .wstrb_i (axi_s_w.wstrb),
    .re_i    (r_state_q == R_FETCH),
    .raddr_i (r_idx_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: bursts, error responses, stalls, reset abort.
module tb_axi_mem_slave;
  import axi_pkg::*;

  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  axi_aw_if #(.AddrWidth(32))  aw_if ();
  axi_w_if  #(.DataWidth(128)) w_if ();
  axi_b_if                     b_if ();
  axi_ar_if #(.AddrWidth(32))  ar_if ();
  axi_r_if  #(.DataWidth(128)) r_if ();

  axi_mem_slave dut (
    .aclk     (aclk),
    .rst      (rst),
    .axi_s_aw (aw_if),
    .axi_s_w  (w_if),
    .axi_s_b  (b_if),
    .axi_s_ar (ar_if),
    .axi_s_r  (r_if)
  );

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct {
    logic [3:0]   id;
    logic [1:0]   resp;
    logic [127:0] data;
    logic         last;
  } rexp_t;

  int           n_chk = 0;
  int           n_err = 0;
  logic [127:0] mdl [1024];
  bexp_t        b_q [$];
  rexp_t        r_q [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Window is 1024 words of 16 bytes starting at 0x2_0000.
  function automatic logic [1:0] tb_decode(input logic [31:0] addr, input logic [1:0] burst);
    if (addr < 32'h0002_0000 || (addr - 32'h0002_0000) >= 32'd16384) return 2'd3;
    if (burst > 2'd1) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int tb_idx(input logic [31:0] addr);
    return int'((addr - 32'h0002_0000) / 32'd16);
  endfunction

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input logic [7:0] d0,
                          input logic [15:0] strb);
    logic [1:0]   er;
    logic [127:0] d;
    int           idx;
    int           n;
    bexp_t        e;
    er  = tb_decode(addr, burst);
    idx = (er == 2'd0) ? tb_idx(addr) : 0;
    for (int k = 0; k < nbeats; k++) begin
      d = {16{d0 + 8'(k)}};
      if (er == 2'd0 && k <= int'(len)) begin
        for (int b = 0; b < 16; b++) if (strb[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        if (burst == 2'd1) idx = (idx + 1) % 1024;
      end
    end
    e.id   = id;
    e.resp = (er != 2'd0) ? er : ((nbeats != int'(len) + 1) ? 2'd2 : 2'd0);
    b_q.push_back(e);

    aw_if.awid = id; aw_if.awaddr = addr; aw_if.awlen = len; aw_if.awburst = burst;
    aw_if.awvalid = 1'b1;
    n = 0;
    while (!aw_if.awready && n < 64) begin @(negedge aclk); n++; end
    chk("aw_ready", aw_if.awready, 1);
    @(negedge aclk);
    aw_if.awvalid = 1'b0;

    for (int k = 0; k < nbeats; k++) begin
      w_if.wdata  = {16{d0 + 8'(k)}};
      w_if.wstrb  = strb;
      w_if.wlast  = (k == nbeats - 1);
      w_if.wvalid = 1'b1;
      n = 0;
      while (!w_if.wready && n < 64) begin @(negedge aclk); n++; end
      if (!w_if.wready) chk("w_ready", w_if.wready, 1);
      @(negedge aclk);
    end
    w_if.wvalid = 1'b0;
    w_if.wlast  = 1'b0;

    n = 0;
    while (!b_if.bvalid && n < 64) begin @(negedge aclk); n++; end
    chk("b_lat", n, 0);
    e = b_q.pop_front();
    chk("bresp", b_if.bresp, e.resp);
    chk("bid", b_if.bid, e.id);
    @(negedge aclk);
    chk("b_done", b_if.bvalid, 0);
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall);
    logic [1:0] er;
    int         idx;
    int         n;
    rexp_t      e;
    er  = tb_decode(addr, burst);
    idx = (er == 2'd0) ? tb_idx(addr) : 0;
    for (int k = 0; k <= int'(len); k++) begin
      e.id   = id;
      e.resp = er;
      e.data = (er == 2'd0) ? mdl[idx] : '0;
      e.last = (k == int'(len));
      r_q.push_back(e);
      if (burst == 2'd1) idx = (idx + 1) % 1024;
    end

    ar_if.arid = id; ar_if.araddr = addr; ar_if.arlen = len; ar_if.arburst = burst;
    ar_if.arvalid = 1'b1;
    n = 0;
    while (!ar_if.arready && n < 64) begin @(negedge aclk); n++; end
    chk("ar_ready", ar_if.arready, 1);
    @(negedge aclk);
    ar_if.arvalid = 1'b0;

    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!r_if.rvalid && n < 64) begin @(negedge aclk); n++; end
      chk("r_lat", n, 1);
      e = r_q.pop_front();
      if (k == stall) begin
        r_if.rready = 1'b0;
        repeat (5) begin
          @(negedge aclk);
          chk("r_hold_v", r_if.rvalid, 1);
          chk("r_hold_d", r_if.rdata, e.data);
          chk("r_hold_l", r_if.rlast, e.last);
        end
        r_if.rready = 1'b1;
      end
      chk("rdata", r_if.rdata, e.data);
      chk("rresp", r_if.rresp, e.resp);
      chk("rlast", r_if.rlast, e.last);
      chk("rid", r_if.rid, e.id);
      @(negedge aclk);
    end
    chk("r_done", r_if.rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    aw_if.awid = '0; aw_if.awaddr = '0; aw_if.awlen = '0; aw_if.awburst = '0; aw_if.awvalid = 1'b0;
    w_if.wdata = '0; w_if.wstrb = '0; w_if.wlast = 1'b0; w_if.wvalid = 1'b0;
    b_if.bready = 1'b1;
    ar_if.arid = '0; ar_if.araddr = '0; ar_if.arlen = '0; ar_if.arburst = '0; ar_if.arvalid = 1'b0;
    r_if.rready = 1'b1;

    repeat (3) @(negedge aclk);
    chk("rst_ctl", {aw_if.awready, w_if.wready, b_if.bvalid, ar_if.arready, r_if.rvalid, r_if.rlast,
                    b_if.bresp, r_if.rresp, b_if.bid, r_if.rid}, 0);
    chk("rst_rdata", r_if.rdata, 0);
    rst = 1'b0;
    #1;
    chk("rdy_reg", {aw_if.awready, ar_if.arready}, 0);
    @(negedge aclk);
    chk("rdy_rise", {aw_if.awready, ar_if.arready}, 2'b11);

    // basic INCR write/read, then a stalled read of the same burst
    wr_burst(4'h5, 32'h0002_0010, 8'd3, 2'd1, 4, 8'hA0, 16'hFFFF);
    rd_burst(4'h3, 32'h0002_0010, 8'd3, 2'd1, -1);
    rd_burst(4'h4, 32'h0002_0010, 8'd3, 2'd1, 1);

    // decode errors
    rd_burst(4'h6, 32'h0001_FFF0, 8'd1, 2'd1, -1);
    wr_burst(4'h8, 32'h0003_0000, 8'd0, 2'd1, 1, 8'h77, 16'hFFFF);
    rd_burst(4'h9, 32'h0002_0010, 8'd3, 2'd1, -1);

    // index wrap at the top of memory
    wr_burst(4'h1, 32'h0002_3FF0, 8'd1, 2'd1, 2, 8'hB0, 16'hFFFF);
    rd_burst(4'h2, 32'h0002_3FF0, 8'd1, 2'd1, -1);
    rd_burst(4'h2, 32'h0002_0000, 8'd0, 2'd1, -1);

    // FIXED bursts
    wr_burst(4'h1, 32'h0002_00A0, 8'd1, 2'd1, 2, 8'hC0, 16'hFFFF);
    wr_burst(4'h2, 32'h0002_00A0, 8'd3, 2'd0, 4, 8'hD0, 16'hFFFF);
    rd_burst(4'h3, 32'h0002_00A0, 8'd1, 2'd1, -1);
    rd_burst(4'h4, 32'h0002_00A0, 8'd2, 2'd0, -1);

    // wlast later than awlen, and earlier than awlen
    wr_burst(4'h3, 32'h0002_0140, 8'd2, 2'd1, 3, 8'hE0, 16'hFFFF);
    wr_burst(4'h4, 32'h0002_0140, 8'd1, 2'd1, 3, 8'hF0, 16'hFFFF);
    rd_burst(4'h5, 32'h0002_0140, 8'd2, 2'd1, -1);
    wr_burst(4'hB, 32'h0002_0280, 8'd3, 2'd1, 2, 8'h55, 16'hFFFF);
    rd_burst(4'hC, 32'h0002_0280, 8'd1, 2'd1, -1);

    // byte strobes and WRAP rejection
    wr_burst(4'h5, 32'h0002_01E0, 8'd0, 2'd1, 1, 8'h11, 16'hFFFF);
    wr_burst(4'h6, 32'h0002_01E0, 8'd0, 2'd1, 1, 8'h22, 16'h000F);
    rd_burst(4'h7, 32'h0002_01E0, 8'd0, 2'd1, -1);
    wr_burst(4'h7, 32'h0002_01E0, 8'd0, 2'd2, 1, 8'h33, 16'hFFFF);
    rd_burst(4'h8, 32'h0002_01E0, 8'd0, 2'd1, -1);
    rd_burst(4'hA, 32'h0002_01E0, 8'd0, 2'd2, -1);

    // reset in the middle of a write burst (two of four beats accepted)
    aw_if.awid = 4'h7; aw_if.awaddr = 32'h0002_0320; aw_if.awlen = 8'd3; aw_if.awburst = 2'd1;
    aw_if.awvalid = 1'b1;
    @(negedge aclk);
    aw_if.awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_if.wdata = {16{8'h60 + 8'(k)}}; w_if.wstrb = 16'hFFFF; w_if.wvalid = 1'b1;
      mdl[50 + k] = {16{8'h60 + 8'(k)}};
      @(negedge aclk);
    end
    w_if.wvalid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      chk("mid_rst_ctl", {aw_if.awready, w_if.wready, b_if.bvalid, ar_if.arready, r_if.rvalid,
                          r_if.rlast, b_if.bresp, r_if.rresp, b_if.bid, r_if.rid}, 0);
      chk("mid_rst_rdata", r_if.rdata, 0);
    end
    rst = 1'b0;
    @(negedge aclk);
    chk("rel_awready", aw_if.awready, 1);
    repeat (4) begin
      chk("no_bvalid", b_if.bvalid, 0);
      @(negedge aclk);
    end
    rd_burst(4'hD, 32'h0002_0320, 8'd1, 2'd1, -1);
    rd_burst(4'hE, 32'h0002_0010, 8'd3, 2'd1, -1);
    wr_burst(4'hF, 32'h0002_0400, 8'd1, 2'd1, 2, 8'h90, 16'hFFFF);
    rd_burst(4'h1, 32'h0002_0400, 8'd1, 2'd1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter AxiBusWidth, default 128, meaning the data width in bits; bytes per beat = AxiBusWidth/8.
REQ-002 SHALL have parameter AddrWidth, default 32, meaning the AXI address width.
REQ-003 SHALL have parameter MemDepth, default 1024, meaning the number of AxiBusWidth-bit words (power of two).
REQ-004 SHALL have parameter BaseAddr, default 32'h0002_0000, meaning the byte address of word 0.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port axi_s_aw, axi_aw_if.slave, AddrWidth: write address (awid, awaddr, awlen[7:0], awburst[1:0], awvalid/awready).
REQ-008 SHALL have port axi_s_w, axi_w_if.slave, AxiBusWidth: write data (wdata, wstrb, wlast, wvalid/wready).
REQ-009 SHALL have port axi_s_b, axi_b_if.slave, 2-bit resp: write response (bid, bresp, bvalid/bready).
REQ-010 SHALL have port axi_s_ar, axi_ar_if.slave, AddrWidth: read address (arid, araddr, arlen[7:0], arburst[1:0], arvalid/arready).
REQ-011 SHALL have port axi_s_r, axi_r_if.slave, AxiBusWidth: read data (rid, rdata, rresp, rlast, rvalid/rready).

Function
REQ-012 SHALL compute word index = (addr - BaseAddr) >> log2(AxiBusWidth/8); the address is in range iff addr >= BaseAddr and index < MemDepth.
REQ-013 SHALL treat every beat as a full-width word; awsize/arsize are ignored; wstrb[i] enables byte i.
REQ-014 SHALL, for INCR bursts, increment the index by 1 per beat, wrapping modulo MemDepth; FIXED bursts SHALL keep the index constant; WRAP or reserved burst types SHALL yield SLVERR, with no memory write and rdata = 0.
REQ-015 SHALL, for an out-of-range start address, yield DECERR for the whole burst, with writes dropped and rdata = 0.
REQ-016 Write FSM SHALL have states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-017 In W_IDLE, awready SHALL be 1; on the AW handshake at cycle N, the FSM SHALL latch id/addr/len/burst and enter W_DATA, with wready = 1 from cycle N+1.
REQ-018 In W_DATA, the FSM SHALL write one beat per wvalid&&wready cycle (write port, 1-cycle latency) and leave on the wlast handshake.
REQ-019 On a wlast/count mismatch (wlast before beat awlen+1, or beats beyond awlen+1 without wlast), the FSM SHALL drop extra beats, keep accepting until wlast, and set bresp = SLVERR.
REQ-020 In W_RESP, bvalid SHALL be 1 starting the cycle after the wlast handshake, with bid = latched awid, held stable until bready; the FSM SHALL then return to W_IDLE with awready = 1 the next cycle.
REQ-021 Read FSM SHALL have states R_IDLE -> R_FETCH -> R_DATA.
REQ-022 In R_IDLE, arready SHALL be 1; the AR handshake at cycle N SHALL lead to R_FETCH at N+1 (memory read issued) and rvalid = 1 at N+2.
REQ-023 In R_DATA, rdata/rresp/rid/rlast SHALL be held stable while rvalid && !rready.
REQ-024 On the R handshake, the FSM SHALL go to R_FETCH for the next beat, or to R_IDLE when rlast (beat arlen+1); peak throughput is one beat per two cycles.
REQ-025 Read and write FSMs SHALL operate concurrently and independently; a same-cycle read and write to the same word SHALL return old data (read-first).
REQ-026 SHALL allow one outstanding burst per direction; AR/AW are not accepted outside the IDLE states.

Reset
REQ-027 While rst = 1, awready, wready, bvalid, arready, rvalid, rlast SHALL be 0, and bresp, rresp, rdata, bid, rid SHALL be 0.
REQ-028 Both FSMs SHALL enter IDLE; awready/arready (registered) SHALL rise on the first clock after rst falls.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no B/R completion; memory contents SHALL NOT be cleared.

Structure
REQ-030 Package axi_pkg SHALL hold burst_t (FIXED=0, INCR=1, WRAP=2), resp_t (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), and the W/R state enums.
REQ-031 Sub-module axi_mem_slave_ram SHALL provide a one-write, one-read synchronous RAM with byte enables, MemDepth x AxiBusWidth, read-first.

Verification
REQ-032 Scenario: AW addr 0x0002_0010, len 3, INCR; 4 beats data 0xA0..0xA3, all wstrb 1 -> bresp OKAY, bid echoed, words 1..4 hold A0..A3; a following AR with the same addr/len returns A0..A3 with rlast on beat 4.
REQ-033 Scenario: rready low 5 cycles during beat 2 -> rdata/rlast/rvalid stable throughout; no beat lost or duplicated.
REQ-034 Scenario: AR addr 0x0001_FFF0, len 1 -> 2 beats, rresp DECERR, rdata 0; AW addr 0x0003_0000 -> bresp DECERR, memory unchanged.
REQ-035 Scenario: INCR write starting at word MemDepth-1, len 1 -> beat 2 lands in word 0; FIXED len 3 -> only the last data remains at one word.
REQ-036 Scenario: awlen 1 but wlast on beat 3 -> bresp SLVERR, only beats 1-2 written; wstrb 16'h000F writes bytes 0-3 only.
REQ-037 Scenario: rst pulsed mid write burst -> all outputs 0 during reset, awready 1 one cycle after release, no bvalid for the aborted burst.
